// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch
// and the load/store path. Data requests win by default; fetch is forced after
// STARVE_LIMIT consecutive data grants made while fetch was waiting.
//
// Handshake: each requester holds its request (if_req, or d_rd/d_wr) and the
// associated address/data stable until its one-cycle *_valid pulse, and may
// raise a new request in the cycle right after that pulse. Toward memory,
// mem_req and all mem_* outputs stay stable until the memory answers with
// mem_ready. mem_ready is only meaningful while a request is outstanding.
//
// Optional feature macro: MEM_TIMEOUT_EN. When defined, a memory wait is
// abandoned after TIMEOUT_CYCLES busy cycles, returning zero data with an err
// pulse. When undefined, a wait never times out and err is constant 0.
//
// dbg_state_o / dbg_starve_o expose the FSM state and starvation counter.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                d_rd,
  input  logic                d_wr,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                stall,
  output logic                err,
  output logic [2:0]          dbg_state_o,
  output logic [3:0]          dbg_starve_o
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BUSY_I = 3'd1,
    S_BUSY_D = 3'd2,
    S_RESP_I = 3'd3,
    S_RESP_D = 3'd4
  } state_e;

  state_e              state_q;
  logic [3:0]          starve_cnt_q;
  logic [3:0]          starve_cnt_d;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [BE_W-1:0]     mem_be_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                if_valid_q;
  logic                d_valid_q;
  logic                d_req;
  logic                grant_data;
  logic                grant_fetch;
  logic                busy;
  logic                timeout;
  logic                done;

  assign busy = (state_q == S_BUSY_I) || (state_q == S_BUSY_D);

`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] wait_cnt_q;
  logic          err_q;

  assign timeout = busy && !mem_ready && (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign err     = err_q;

  // Count busy cycles without mem_ready; zero whenever not busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else if (busy) begin
      if (!mem_ready) wait_cnt_q <= wait_cnt_q + 1'b1;
    end else begin
      wait_cnt_q <= '0;
    end
  end

  // err pulses during the response cycle of an abandoned request.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= timeout;
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  assign done = mem_ready || timeout;

  // Arbitration decision and next starvation count, evaluated in IDLE.
  always_comb begin
    d_req        = d_rd | d_wr;
    grant_data   = d_req && !(if_req && (starve_cnt_q == LIMIT));
    grant_fetch  = if_req && !grant_data;
    starve_cnt_d = starve_cnt_q;
    if (state_q == S_IDLE) begin
      if (!if_req || grant_fetch) begin
        starve_cnt_d = 4'd0;
      end else if (grant_data && (starve_cnt_q != LIMIT)) begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end
  end

  // Main FSM with registered memory drive and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      starve_cnt_q <= 4'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_valid_q   <= 1'b0;
      d_valid_q    <= 1'b0;
    end else begin
      if_valid_q   <= 1'b0;
      d_valid_q    <= 1'b0;
      starve_cnt_q <= starve_cnt_d;
      case (state_q)
        S_IDLE: begin
          if (grant_data) begin
            state_q     <= S_BUSY_D;
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_wr;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
            mem_be_q    <= d_be;
          end else if (grant_fetch) begin
            state_q     <= S_BUSY_I;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr;
            mem_wdata_q <= '0;
            mem_be_q    <= '1;
          end
        end
        S_BUSY_I: begin
          if (done) begin
            state_q    <= S_RESP_I;
            mem_req_q  <= 1'b0;
            if_rdata_q <= timeout ? '0 : mem_rdata;
            if_valid_q <= 1'b1;
          end
        end
        S_BUSY_D: begin
          if (done) begin
            state_q   <= S_RESP_D;
            mem_req_q <= 1'b0;
            // Writes return zero so stale read data never leaks out.
            d_rdata_q <= (timeout || mem_we_q) ? '0 : mem_rdata;
            d_valid_q <= 1'b1;
          end
        end
        S_RESP_I, S_RESP_D: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_be       = mem_be_q;
  assign if_rdata     = if_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign if_valid     = if_valid_q;
  assign d_valid      = d_valid_q;
  assign stall        = (if_req & ~if_valid_q) | (d_req & ~d_valid_q);
  assign dbg_state_o  = state_q;
  assign dbg_starve_o = starve_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: scenario tasks plus a randomized run,
// checked against a transaction-level model of arbitration and responses.
module tb_mem_port_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int LIMIT = 4;
  localparam int TMO   = 8;
  localparam logic [2:0] ST_IDLE = 3'd0;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          d_rd;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [BW-1:0] d_be;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          stall;
  logic          err;
  logic [2:0]    dbg_state_o;
  logic [3:0]    dbg_starve_o;

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard: read data expected at the next completion.
  logic [DW-1:0] exp_q[$];
  int            starve_m;
  logic [DW-1:0] if_rdata_m;
  logic [DW-1:0] d_rdata_m;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall(stall), .err(err), .dbg_state_o(dbg_state_o), .dbg_starve_o(dbg_starve_o)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One arbitration round starting at the negedge of an IDLE cycle.
  task automatic do_txn(input logic f, input logic [AW-1:0] fa,
                        input logic rd, input logic wr, input logic [AW-1:0] da,
                        input logic [DW-1:0] wd, input logic [BW-1:0] be,
                        input int wait_n, input logic [DW-1:0] rdat,
                        input logic junk, output int winner);
    logic          dreq;
    logic          fetch_wins;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [BW-1:0] e_be;
    logic          e_stall;
    dreq = rd | wr;
    if_req = f; if_addr = fa; d_rd = rd; d_wr = wr;
    d_addr = da; d_wdata = wd; d_be = be;
    mem_ready = junk; mem_rdata = $urandom;
    #1;
    n_cmp++;
    if (stall !== (f | dreq)) begin
      n_err++; $display("FAIL idle_stall: got %b want %b", stall, f | dreq);
    end
    n_cmp++;
    if (dbg_state_o !== ST_IDLE) begin
      n_err++; $display("FAIL idle_state: got %0d want %0d", dbg_state_o, ST_IDLE);
    end
    // Reference arbitration
    fetch_wins = f && (!dreq || starve_m == LIMIT);
    if (fetch_wins) begin
      winner = 1; starve_m = 0;
    end else if (dreq) begin
      winner = 2;
      if (f) starve_m = (starve_m < LIMIT) ? starve_m + 1 : LIMIT;
      else   starve_m = 0;
    end else begin
      winner = 0; starve_m = 0;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    if (winner == 0) begin
      n_cmp++;
      if (mem_req !== 1'b0) begin
        n_err++; $display("FAIL idle_no_req: got mem_req %b want 0", mem_req);
      end
      return;
    end
    e_we   = (winner == 2) && wr;
    e_addr = (winner == 1) ? fa : da;
    e_be   = (winner == 1) ? {BW{1'b1}} : be;
    for (int i = 0; i <= wait_n; i++) begin
      n_cmp++;
      if (mem_req !== 1'b1 || mem_we !== e_we || mem_addr !== e_addr || mem_be !== e_be) begin
        n_err++;
        $display("FAIL busy_drive: got req=%b we=%b addr=%h be=%h want req=1 we=%b addr=%h be=%h",
                 mem_req, mem_we, mem_addr, mem_be, e_we, e_addr, e_be);
      end
      if (winner == 2 && wr) begin
        n_cmp++;
        if (mem_wdata !== wd) begin
          n_err++; $display("FAIL busy_wdata: got %h want %h", mem_wdata, wd);
        end
      end
      n_cmp++;
      if (if_valid !== 1'b0 || d_valid !== 1'b0 || err !== 1'b0 || stall !== (f | dreq)) begin
        n_err++;
        $display("FAIL busy_flags: got ifv=%b dv=%b err=%b stall=%b want 0 0 0 %b",
                 if_valid, d_valid, err, stall, f | dreq);
      end
      if (i < wait_n) begin
        mem_ready = 1'b0; mem_rdata = $urandom;
        @(negedge clk);
      end
    end
    n_cmp++;
    if (dbg_starve_o !== 4'(starve_m)) begin
      n_err++; $display("FAIL starve_cnt: got %0d want %0d", dbg_starve_o, starve_m);
    end
    exp_q.push_back((winner == 2 && wr) ? '0 : rdat);
    mem_ready = 1'b1; mem_rdata = rdat;
    @(negedge clk);
    mem_ready = junk; mem_rdata = $urandom;
    if (winner == 1) if_rdata_m = exp_q.pop_front();
    else             d_rdata_m  = exp_q.pop_front();
    e_stall = (f && winner != 1) || (dreq && winner != 2);
    n_cmp++;
    if (if_valid !== (winner == 1) || d_valid !== (winner == 2) || mem_req !== 1'b0 ||
        err !== 1'b0 || stall !== e_stall) begin
      n_err++;
      $display("FAIL resp_flags: got ifv=%b dv=%b req=%b err=%b stall=%b want %b %b 0 0 %b",
               if_valid, d_valid, mem_req, err, stall, winner == 1, winner == 2, e_stall);
    end
    n_cmp++;
    if (if_rdata !== if_rdata_m || d_rdata !== d_rdata_m) begin
      n_err++;
      $display("FAIL resp_rdata: got if=%h d=%h want if=%h d=%h",
               if_rdata, d_rdata, if_rdata_m, d_rdata_m);
    end
    if (winner == 1) if_req = 1'b0;
    else begin d_rd = 1'b0; d_wr = 1'b0; end
    @(negedge clk);
    mem_ready = 1'b0;
    n_cmp++;
    if (if_valid !== 1'b0 || d_valid !== 1'b0 || mem_req !== 1'b0 ||
        if_rdata !== if_rdata_m || d_rdata !== d_rdata_m) begin
      n_err++;
      $display("FAIL after_resp: got ifv=%b dv=%b req=%b if=%h d=%h want 0 0 0 %h %h",
               if_valid, d_valid, mem_req, if_rdata, d_rdata, if_rdata_m, d_rdata_m);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; if_req = 0; if_addr = '0; d_rd = 0; d_wr = 0; d_addr = '0;
    d_wdata = '0; d_be = '0; mem_rdata = '0; mem_ready = 0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (mem_req !== 0 || mem_we !== 0 || mem_addr !== '0 || mem_wdata !== '0 ||
        mem_be !== '0 || if_rdata !== '0 || d_rdata !== '0 || if_valid !== 0 ||
        d_valid !== 0 || err !== 0 || stall !== 0) begin
      n_err++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h wd=%h be=%h ir=%h dr=%h iv=%b dv=%b err=%b stall=%b want all 0",
               mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_rdata, d_rdata,
               if_valid, d_valid, err, stall);
    end
    n_cmp++;
    if (dbg_state_o !== ST_IDLE || dbg_starve_o !== 4'd0) begin
      n_err++; $display("FAIL reset_state: got st=%0d sc=%0d want 0 0", dbg_state_o, dbg_starve_o);
    end
    rst = 1'b0;
    starve_m = 0; if_rdata_m = '0; d_rdata_m = '0;
    @(negedge clk);
  endtask

  task automatic test_fetch_basic;
    int w;
    do_txn(1, 32'h100, 0, 0, '0, '0, '0, 0, 32'h00A00093, 0, w);
    n_cmp++;
    if (w != 1) begin n_err++; $display("FAIL fetch_basic_grant: got %0d want 1", w); end
  endtask

  task automatic test_priority;
    int w1, w2;
    do_txn(1, 32'h300, 1, 0, 32'h200, '0, 4'hF, 0, 32'h11223344, 0, w1);
    do_txn(1, 32'h300, 0, 0, '0, '0, '0, 0, 32'h55667788, 0, w2);
    n_cmp++;
    if (w1 != 2 || w2 != 1) begin
      n_err++; $display("FAIL priority_order: got %0d,%0d want 2,1", w1, w2);
    end
  endtask

  task automatic test_starvation;
    int w;
    do_txn(0, '0, 0, 0, '0, '0, '0, 0, '0, 0, w);
    for (int i = 0; i < 6; i++) begin
      do_txn(1, 32'h400, 1, 0, 32'h500 + 32'(i * 4), '0, 4'hF,
             $urandom_range(0, 2), $urandom, 0, w);
      n_cmp++;
      if (w != ((i == 4) ? 1 : 2)) begin
        n_err++; $display("FAIL starve_grant%0d: got %0d want %0d", i, w, (i == 4) ? 1 : 2);
      end
    end
  endtask

  task automatic test_write;
    int w;
    do_txn(0, '0, 0, 1, 32'h600, 32'hDEADBEEF, 4'b0011, 3, 32'hCAFEF00D, 0, w);
    do_txn(0, '0, 1, 1, 32'h604, 32'h0BADF00D, 4'b1100, 1, 32'h12345678, 1, w);
  endtask

  task automatic test_reset_mid;
    if_req = 0; d_rd = 1; d_wr = 0; d_addr = 32'h700; d_be = 4'hF; mem_ready = 0;
    @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b1) begin n_err++; $display("FAIL rst_mid_busy: got %b want 1", mem_req); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; d_rd = 0; mem_ready = 1; mem_rdata = 32'hA5A5A5A5;
    n_cmp++;
    if (mem_req !== 0 || mem_we !== 0 || mem_addr !== '0 || mem_be !== '0 ||
        d_rdata !== '0 || if_rdata !== '0 || d_valid !== 0 || dbg_state_o !== ST_IDLE) begin
      n_err++;
      $display("FAIL rst_mid_clear: got req=%b we=%b addr=%h be=%h dr=%h ir=%h dv=%b st=%0d want all 0",
               mem_req, mem_we, mem_addr, mem_be, d_rdata, if_rdata, d_valid, dbg_state_o);
    end
    @(negedge clk);
    mem_ready = 0;
    n_cmp++;
    if (d_valid !== 0 || if_valid !== 0 || mem_req !== 0 || d_rdata !== '0) begin
      n_err++;
      $display("FAIL rst_mid_late_ready: got dv=%b iv=%b req=%b dr=%h want 0 0 0 0",
               d_valid, if_valid, mem_req, d_rdata);
    end
    starve_m = 0; if_rdata_m = '0; d_rdata_m = '0;
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout;
    int cnt;
    if_req = 1; if_addr = 32'h800; d_rd = 0; d_wr = 0; mem_ready = 0;
    @(negedge clk);
    cnt = 0;
    while (mem_req === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    n_cmp++;
    if (cnt != TMO) begin n_err++; $display("FAIL timeout_len: got %0d want %0d", cnt, TMO); end
    n_cmp++;
    if (if_valid !== 1 || err !== 1 || if_rdata !== '0) begin
      n_err++; $display("FAIL timeout_resp: got iv=%b err=%b ir=%h want 1 1 0", if_valid, err, if_rdata);
    end
    if_req = 0;
    @(negedge clk);
    n_cmp++;
    if (err !== 0 || if_valid !== 0) begin
      n_err++; $display("FAIL timeout_pulse: got err=%b iv=%b want 0 0", err, if_valid);
    end
    starve_m = 0; if_rdata_m = '0;
  endtask
`else
  task automatic test_long_wait;
    int w;
    do_txn(1, 32'h900, 0, 0, '0, '0, '0, 3 * TMO, 32'h76543210, 0, w);
  endtask
`endif

  task automatic test_random;
    logic f, rd, wr;
    logic [AW-1:0] fa, da;
    logic [DW-1:0] wd;
    logic [BW-1:0] be;
    int k, w;
    f = 0; rd = 0; wr = 0; fa = '0; da = '0; wd = '0; be = '0;
    for (int t = 0; t < 80; t++) begin
      if (!f && $urandom_range(0, 3) != 0) begin
        f = 1; fa = $urandom & 32'hFFFF_FFFC;
      end
      if (!rd && !wr && $urandom_range(0, 3) != 0) begin
        k = $urandom_range(0, 2);
        rd = (k != 1); wr = (k != 0);
        da = $urandom & 32'hFFFF_FFFC; wd = $urandom; be = 4'($urandom_range(0, 15));
      end
      do_txn(f, fa, rd, wr, da, wd, be, $urandom_range(0, 4), $urandom,
             1'($urandom_range(0, 1)), w);
      if (w == 1) f = 0;
      else if (w == 2) begin rd = 0; wr = 0; end
    end
  endtask

  initial begin
    test_reset();
    test_fetch_basic();
    test_priority();
    test_starvation();
    test_write();
    test_reset_mid();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
